jtag_user_cmd: RTL and testbench

- JTAG user-register command block for the DMB controller, clocked by CLKCMS.
- Takes the raw BSCAN user-chain signals (TCK domain), synchronises and edge-detects them, and shifts an 8-bit function code on USER1 and a data word on USER2.
- Decodes the function code to load calibration delays and the trigger-rate register, reset defaults, toggle random triggers, and launch trigger bursts.
- Downstream trigger control consumes the delay and trigger outputs.

---
 rtl/jtag_user_cmd.sv | 244 ++++++++++++++++++++++++
 tb/tb_jtag_user_cmd.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_user_cmd.sv
// -----------------------------------------------------------------------------
// jtag_user_cmd
//
// JTAG user-register command block for the DMB controller (CLKCMS domain).
// The raw BSCAN user-chain signals come from the TCK domain. They are
// synchronised into CLKCMS and edge-detected. An 8-bit function code is
// shifted on USER1 and a data word on USER2. The function code then drives
// calibration delay loads, trigger-rate loads, default restore, random-trigger
// enable toggling and fixed-length trigger bursts.
//
// Ports
//   CLKCMS        in   system clock (40 MHz)
//   RST           in   synchronous active-high reset
//   JDRCK         in   BSCAN data clock (TCK-gated), asynchronous
//   JSEL1/JSEL2   in   USER1 / USER2 selected
//   JSHIFT        in   TAP in Shift-DR
//   JCAPTURE      in   TAP in Capture-DR
//   JUPDATE       in   TAP in Update-DR
//   JTDI          in   serial data in
//   STATUS[15:0]  in   status word for readback (only with STATUS_RDBK_EN)
//   JTDO          out  registered LSB of the selected shift register
//   FUNC[7:0]     out  current function code
//   INJDLY[4:0]   out  inject delay
//   EXTDLY[4:0]   out  external-pulse delay
//   CALL1ADLY[4:0] out calibration L1A delay
//   CALLCTDLY[3:0] out calibration LCT delay
//   TRGRATE[17:0] out  random-trigger period (pulse every TRGRATE+1 cycles)
//   RTRG_EN       out  random triggers enabled
//   RTRG          out  one-cycle trigger pulse (random OR burst)
//   BURST_ACTIVE  out  burst in progress
//
// Optional feature macro: STATUS_RDBK_EN
//   When defined, adds the STATUS input. A USER2 capture then loads STATUS
//   (FUNC 0x03) or the current delay / rate register (FUNC 0x11 / 0x13),
//   right-aligned, so it can be read back on JTDO. When undefined, a USER2
//   capture always clears sr2.
//
// TCK must be no faster than CLKCMS/4 so that every JDRCK level is seen by
// the synchronisers for at least two CLKCMS cycles.
// -----------------------------------------------------------------------------
module jtag_user_cmd #(
  parameter int BURST_LEN = 16,
  parameter int BURST_GAP = 8
) (
  input  logic        CLKCMS,
  input  logic        RST,
  input  logic        JDRCK,
  input  logic        JSEL1,
  input  logic        JSEL2,
  input  logic        JSHIFT,
  input  logic        JCAPTURE,
  input  logic        JUPDATE,
  input  logic        JTDI,
`ifdef STATUS_RDBK_EN
  input  logic [15:0] STATUS,
`endif
  output logic        JTDO,
  output logic [7:0]  FUNC,
  output logic [4:0]  INJDLY,
  output logic [4:0]  EXTDLY,
  output logic [4:0]  CALL1ADLY,
  output logic [3:0]  CALLCTDLY,
  output logic [17:0] TRGRATE,
  output logic        RTRG_EN,
  output logic        RTRG,
  output logic        BURST_ACTIVE
);

  localparam logic [7:0]  FN_STATUS  = 8'h03;
  localparam logic [7:0]  FN_DEFAULT = 8'h02;
  localparam logic [7:0]  FN_DELAYS  = 8'h11;
  localparam logic [7:0]  FN_RATE    = 8'h13;
  localparam logic [7:0]  FN_RTRG_TG = 8'h14;
  localparam logic [7:0]  FN_BURST   = 8'h20;
  localparam logic [17:0] RATE_DFLT  = 18'h3FFFF;

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int GW  = (BURST_GAP > 2) ? $clog2(BURST_GAP) : 1;

  // ---------------------------------------------------------------------------
  // Synchronisers. Stages [1:0] form the 2-FF synchroniser. Stage [2] is only
  // kept on the signals whose rising edge is used.
  // ---------------------------------------------------------------------------
  logic [2:0] drck_sr, cap_sr, upd_sr;
  logic [1:0] sel1_sr, sel2_sr, shift_sr, tdi_sr;

  always_ff @(posedge CLKCMS) begin
    if (RST) begin
      drck_sr  <= '0;
      cap_sr   <= '0;
      upd_sr   <= '0;
      sel1_sr  <= '0;
      sel2_sr  <= '0;
      shift_sr <= '0;
      tdi_sr   <= '0;
    end else begin
      drck_sr  <= {drck_sr[1:0], JDRCK};
      cap_sr   <= {cap_sr[1:0],  JCAPTURE};
      upd_sr   <= {upd_sr[1:0],  JUPDATE};
      sel1_sr  <= {sel1_sr[0],   JSEL1};
      sel2_sr  <= {sel2_sr[0],   JSEL2};
      shift_sr <= {shift_sr[0],  JSHIFT};
      tdi_sr   <= {tdi_sr[0],    JTDI};
    end
  end

  logic drck_re, cap_re, upd_re, sel1_s, sel2_s, shift_s, tdi_s;
  assign drck_re = drck_sr[1] & ~drck_sr[2];
  assign cap_re  = cap_sr[1]  & ~cap_sr[2];
  assign upd_re  = upd_sr[1]  & ~upd_sr[2];
  assign sel1_s  = sel1_sr[1];
  assign sel2_s  = sel2_sr[1];
  assign shift_s = shift_sr[1];
  assign tdi_s   = tdi_sr[1];

  // ---------------------------------------------------------------------------
  // Shift registers and JTDO
  // ---------------------------------------------------------------------------
  logic [7:0]  sr1;
  logic [31:0] sr2;
  logic [31:0] cap_val;

  always_comb begin
    cap_val = '0;
`ifdef STATUS_RDBK_EN
    case (FUNC)
      FN_STATUS: cap_val = {16'b0, STATUS};
      FN_DELAYS: cap_val = {13'b0, INJDLY, EXTDLY, CALL1ADLY, CALLCTDLY};
      FN_RATE:   cap_val = {14'b0, TRGRATE};
      default:   cap_val = '0;
    endcase
`endif
  end

  always_ff @(posedge CLKCMS) begin
    if (RST) begin
      sr1  <= '0;
      sr2  <= '0;
      JTDO <= 1'b0;
    end else begin
      if (drck_re && sel1_s && shift_s)
        sr1 <= {tdi_s, sr1[7:1]};
      // Capture takes priority. The TAP never captures and shifts in the
      // same DRCK period anyway.
      if (cap_re && sel2_s)
        sr2 <= cap_val;
      else if (drck_re && sel2_s && shift_s)
        sr2 <= {tdi_s, sr2[31:1]};
      JTDO <= sel1_s ? sr1[0] : (sel2_s ? sr2[0] : 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Command / register control, random trigger and burst generator
  // ---------------------------------------------------------------------------
  logic             cmd_go;     // one cycle after a USER1 update
  logic [17:0]      rnd_cnt;
  logic [BCW-1:0]   burst_cnt;  // pulses already issued in this burst
  logic [GW-1:0]    gap_cnt;
  logic             rnd_hit;
  logic             burst_fire;

  assign rnd_hit    = RTRG_EN && (rnd_cnt == TRGRATE);
  assign burst_fire = BURST_ACTIVE && (burst_cnt != BCW'(BURST_LEN)) &&
                      (gap_cnt == '0);

  always_ff @(posedge CLKCMS) begin
    if (RST) begin
      cmd_go       <= 1'b0;
      FUNC         <= '0;
      INJDLY       <= '0;
      EXTDLY       <= '0;
      CALL1ADLY    <= '0;
      CALLCTDLY    <= '0;
      TRGRATE      <= RATE_DFLT;
      RTRG_EN      <= 1'b0;
      RTRG         <= 1'b0;
      BURST_ACTIVE <= 1'b0;
      rnd_cnt      <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
    end else begin
      cmd_go <= upd_re & sel1_s;

      // USER1 update wins if both selects were somehow active together.
      if (upd_re && sel1_s) begin
        FUNC <= sr1;
      end else if (upd_re && sel2_s) begin
        case (FUNC)
          FN_DELAYS: {INJDLY, EXTDLY, CALL1ADLY, CALLCTDLY} <= sr2[31:13];
          FN_RATE:   TRGRATE <= sr2[31:14];
          default:   ;
        endcase
      end

      // Random trigger counter: period is TRGRATE+1 cycles.
      if (!RTRG_EN)     rnd_cnt <= '0;
      else if (rnd_hit) rnd_cnt <= '0;
      else              rnd_cnt <= rnd_cnt + 18'd1;

      // Burst: a pulse whenever the gap counter is zero. After the last
      // pulse the burst closes on the following cycle.
      if (BURST_ACTIVE) begin
        if (burst_cnt == BCW'(BURST_LEN)) begin
          BURST_ACTIVE <= 1'b0;
        end else if (gap_cnt == '0) begin
          burst_cnt <= burst_cnt + BCW'(1);
          gap_cnt   <= GW'(BURST_GAP - 1);
        end else begin
          gap_cnt <= gap_cnt - GW'(1);
        end
      end

      RTRG <= rnd_hit | burst_fire;

      // Immediate commands override the generator updates above.
      if (cmd_go) begin
        case (FUNC)
          FN_DEFAULT: begin
            INJDLY       <= '0;
            EXTDLY       <= '0;
            CALL1ADLY    <= '0;
            CALLCTDLY    <= '0;
            TRGRATE      <= RATE_DFLT;
            RTRG_EN      <= 1'b0;
            BURST_ACTIVE <= 1'b0;
            burst_cnt    <= '0;
            gap_cnt      <= '0;
          end
          FN_RTRG_TG: RTRG_EN <= ~RTRG_EN;
          FN_BURST: begin
            if (!BURST_ACTIVE) begin
              BURST_ACTIVE <= 1'b1;
              burst_cnt    <= '0;
              gap_cnt      <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_user_cmd.sv
`timescale 1ns/100ps
module tb_jtag_user_cmd;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        CLKCMS = 1'b0;
  logic        RST    = 1'b1;
  logic        JDRCK = 1'b0, JSEL1 = 1'b0, JSEL2 = 1'b0, JSHIFT = 1'b0;
  logic        JCAPTURE = 1'b0, JUPDATE = 1'b0, JTDI = 1'b0;
`ifdef STATUS_RDBK_EN
  logic [15:0] STATUS = 16'hA5C3;
`endif
  logic        JTDO;
  logic [7:0]  FUNC;
  logic [4:0]  INJDLY, EXTDLY, CALL1ADLY;
  logic [3:0]  CALLCTDLY;
  logic [17:0] TRGRATE;
  logic        RTRG_EN, RTRG, BURST_ACTIVE;

  always #12.5 CLKCMS = ~CLKCMS;

  jtag_user_cmd #(.BURST_LEN(16), .BURST_GAP(8)) dut (
    .CLKCMS(CLKCMS), .RST(RST), .JDRCK(JDRCK), .JSEL1(JSEL1), .JSEL2(JSEL2),
    .JSHIFT(JSHIFT), .JCAPTURE(JCAPTURE), .JUPDATE(JUPDATE), .JTDI(JTDI),
`ifdef STATUS_RDBK_EN
    .STATUS(STATUS),
`endif
    .JTDO(JTDO), .FUNC(FUNC), .INJDLY(INJDLY), .EXTDLY(EXTDLY),
    .CALL1ADLY(CALL1ADLY), .CALLCTDLY(CALLCTDLY), .TRGRATE(TRGRATE),
    .RTRG_EN(RTRG_EN), .RTRG(RTRG), .BURST_ACTIVE(BURST_ACTIVE)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_noexp"}, got, ~got);
    else check(tag, got, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   pulse_q[$];
  int   rise_q[$];
  int   act_cycles = 0;
  logic prev_act = 1'b0;

  always @(negedge CLKCMS) begin
    cyc++;
    if (mon_en) begin
      if (RTRG === 1'b1) pulse_q.push_back(cyc);
      if (BURST_ACTIVE === 1'b1) act_cycles++;
      if (BURST_ACTIVE === 1'b1 && prev_act !== 1'b1) rise_q.push_back(cyc);
    end
    prev_act = BURST_ACTIVE;
  end

  task automatic mon_start();
    pulse_q.delete();
    rise_q.delete();
    act_cycles = 0;
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: every JTAG phase is held 4 CLKCMS cycles (TCK = CLKCMS/8)
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLKCMS);
  endtask

  task automatic jtag_capture(input bit user2);
    JSEL1 = !user2;
    JSEL2 = user2;
    wait_clk(4);
    JCAPTURE = 1'b1;
    wait_clk(4);
    JCAPTURE = 1'b0;
    JSHIFT = 1'b1;
    wait_clk(4);
  endtask

  task automatic jtag_bits(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      JTDI = data[i];
      wait_clk(4);
      JDRCK = 1'b1;
      wait_clk(4);
      JDRCK = 1'b0;
    end
  endtask

  task automatic jtag_update();
    JSHIFT = 1'b0;
    wait_clk(4);
    JUPDATE = 1'b1;
    wait_clk(4);
    JUPDATE = 1'b0;
    wait_clk(4);
    JSEL1 = 1'b0;
    JSEL2 = 1'b0;
    wait_clk(4);
  endtask

  task automatic user1(input logic [7:0] code);
    jtag_capture(1'b0);
    jtag_bits({24'b0, code}, 8);
    // After 8 shifts sr1 holds the code, so JTDO shows its LSB.
    check("jtdo_user1", {31'b0, JTDO}, {31'b0, code[0]});
    jtag_update();
  endtask

  task automatic user2(input logic [31:0] data, input int n);
    jtag_capture(1'b1);
    jtag_bits(data, n);
    jtag_update();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset for 5 cycles
    RST = 1'b1;
    wait_clk(5);
    RST = 1'b0;
    wait_clk(2);
    check("rst_func",    FUNC,      32'h0);
    check("rst_injdly",  INJDLY,    32'h0);
    check("rst_extdly",  EXTDLY,    32'h0);
    check("rst_l1adly",  CALL1ADLY, 32'h0);
    check("rst_lctdly",  CALLCTDLY, 32'h0);
    check("rst_trgrate", TRGRATE,   32'h3FFFF);
    check("rst_rtrg_en", RTRG_EN,   32'h0);
    check("rst_burst",   BURST_ACTIVE, 32'h0);
    check("rst_jtdo",    JTDO,      32'h0);
    mon_start();
    wait_clk(1000);
    mon_en = 1'b0;
    check("rst_no_rtrg", pulse_q.size(), 32'd0);

    // Delay load: {15,13,11,8}
    expect_val(32'h11); expect_val(15); expect_val(13); expect_val(11);
    expect_val(8);
    user1(8'h11);
    user2({13'b0, 5'd15, 5'd13, 5'd11, 4'd8}, 19);
    pop_check("dly_func",   FUNC);
    pop_check("dly_injdly", INJDLY);
    pop_check("dly_extdly", EXTDLY);
    pop_check("dly_l1adly", CALL1ADLY);
    pop_check("dly_lctdly", CALLCTDLY);

    // Trigger rate 9, enable random triggers -> period 10
    user1(8'h13);
    user2(32'd9, 18);
    check("rate_load", TRGRATE, 32'd9);
    user1(8'h14);
    check("rnd_en_on", RTRG_EN, 32'h1);
    for (int i = 0; i < 9; i++) expect_val(10);
    mon_start();
    wait_clk(105);
    mon_en = 1'b0;
    check("rnd_enough", {31'b0, pulse_q.size() >= 10}, 32'h1);
    for (int i = 1; i < 10; i++) begin
      if (i < pulse_q.size()) pop_check("rnd_gap", pulse_q[i] - pulse_q[i-1]);
      else pop_check("rnd_gap_missing", 32'hFFFF_FFFF);
    end
    user1(8'h14);
    wait_clk(2);
    check("rnd_en_off", RTRG_EN, 32'h0);
    mon_start();
    wait_clk(50);
    mon_en = 1'b0;
    check("rnd_stopped", pulse_q.size(), 32'd0);

    // Burst, with a second start request mid-burst
    expect_val(1);                        // one rising edge of BURST_ACTIVE
    expect_val(16);                       // pulses
    expect_val(1);                        // first pulse offset
    for (int i = 0; i < 15; i++) expect_val(8);
    expect_val(2 + 15 * 8);               // BURST_ACTIVE high cycles
    mon_start();
    user1(8'h20);
    user1(8'h20);
    check("burst_still_on", BURST_ACTIVE, 32'h1);
    wait_clk(80);
    mon_en = 1'b0;
    check("burst_done", BURST_ACTIVE, 32'h0);
    pop_check("burst_rises", rise_q.size());
    pop_check("burst_pulses", pulse_q.size());
    if (rise_q.size() > 0 && pulse_q.size() > 0)
      pop_check("burst_first", pulse_q[0] - rise_q[0]);
    else
      pop_check("burst_first_missing", 32'hFFFF_FFFF);
    for (int i = 1; i < 16; i++) begin
      if (i < pulse_q.size()) pop_check("burst_gap", pulse_q[i] - pulse_q[i-1]);
      else pop_check("burst_gap_missing", 32'hFFFF_FFFF);
    end
    pop_check("burst_active_len", act_cycles);

    // Defaults restore (enable random triggers first so the clear is visible)
    user1(8'h14);
    check("dflt_pre_en", RTRG_EN, 32'h1);
    user1(8'h02);
    check("dflt_func",    FUNC,      32'h02);
    check("dflt_injdly",  INJDLY,    32'h0);
    check("dflt_extdly",  EXTDLY,    32'h0);
    check("dflt_l1adly",  CALL1ADLY, 32'h0);
    check("dflt_lctdly",  CALLCTDLY, 32'h0);
    check("dflt_trgrate", TRGRATE,   32'h3FFFF);
    check("dflt_rtrg_en", RTRG_EN,   32'h0);

    // USER2 update under an unrelated function loads nothing
    user2(32'h5A5A5, 19);
    check("noop_injdly",  INJDLY,  32'h0);
    check("noop_trgrate", TRGRATE, 32'h3FFFF);

    // Reset in the middle of a USER2 shift, then a clean all-ones load
    user1(8'h11);
    jtag_capture(1'b1);
    jtag_bits(32'h0000_0155, 10);
    RST = 1'b1;
    JSEL2 = 1'b0;
    JSHIFT = 1'b0;
    JTDI = 1'b0;
    wait_clk(3);
    RST = 1'b0;
    wait_clk(4);
    check("abort_func",   FUNC,   32'h0);
    check("abort_injdly", INJDLY, 32'h0);
    check("abort_jtdo",   JTDO,   32'h0);
    expect_val(5'h1F); expect_val(5'h1F); expect_val(5'h1F); expect_val(4'hF);
    user1(8'h11);
    user2(32'h7FFFF, 19);
    pop_check("ones_injdly", INJDLY);
    pop_check("ones_extdly", EXTDLY);
    pop_check("ones_l1adly", CALL1ADLY);
    pop_check("ones_lctdly", CALLCTDLY);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
